// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of a fixed-latency data memory: port 0 has priority,
// a saturating starvation counter forces a port-1 grant after STARVE_LIMIT port-0 wins.
module dm_port_arbiter #(
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        CLK,
    input  logic        RESET,

    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [1:0]  req0_size,
    output logic        req0_ready,
    output logic        req0_rvalid,
    output logic [31:0] req0_rdata,

    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [1:0]  req1_size,
    output logic        req1_ready,
    output logic        req1_rvalid,
    output logic [31:0] req1_rdata,

    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [1:0]  dm_size,
    output logic        dm_read,
    output logic        dm_write,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_INIT  = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LV = 4'(STARVE_LIMIT);

    state_t      r_state;
    logic        r_owner;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic [3:0]  r_lat_cnt;
    logic [3:0]  r_starve_cnt;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic        w_idle;
    logic        w_busy;
    logic        w_resp;
    logic        w_trip;
    logic        w_grant0;
    logic        w_grant1;

    // Ready is combinational, so it must also be masked while reset is held.
    assign w_idle   = (r_state == S_IDLE) && RESET;
    assign w_busy   = (r_state == S_BUSY);
    assign w_resp   = (r_state == S_RESP);
    assign w_trip   = (STARVE_LIMIT != 0) && (r_starve_cnt == STARVE_LV);
    assign w_grant1 = w_idle && req1_valid && (!req0_valid || w_trip);
    assign w_grant0 = w_idle && req0_valid && !w_grant1;

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign req0_rvalid = w_resp && !r_owner;
    assign req1_rvalid = w_resp && r_owner;
    assign req0_rdata  = r_rdata0;
    assign req1_rdata  = r_rdata1;

    assign dm_addr  = w_busy ? r_addr  : 32'd0;
    assign dm_wdata = w_busy ? r_wdata : 32'd0;
    assign dm_size  = w_busy ? r_size  : 2'd0;
    assign dm_read  = w_busy && !r_write;
    assign dm_write = w_busy && r_write;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_size       <= 2'd0;
            r_lat_cnt    <= 4'd0;
            r_starve_cnt <= 4'd0;
            r_rdata0     <= 32'd0;
            r_rdata1     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_owner   <= w_grant1;
                        r_write   <= w_grant1 ? req1_write : req0_write;
                        r_addr    <= w_grant1 ? req1_addr  : req0_addr;
                        r_wdata   <= w_grant1 ? req1_wdata : req0_wdata;
                        r_size    <= w_grant1 ? req1_size  : req0_size;
                        r_lat_cnt <= LAT_INIT;
                        r_state   <= S_BUSY;
                        // Only a port-0 win over a waiting port 1 counts as starvation.
                        if (w_grant0 && req1_valid) begin
                            if (r_starve_cnt != 4'd15) begin
                                r_starve_cnt <= r_starve_cnt + 4'd1;
                            end
                        end else begin
                            r_starve_cnt <= 4'd0;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_lat_cnt == 4'd0) begin
                        if (r_owner) begin
                            r_rdata1 <= r_write ? 32'd0 : dm_rdata;
                        end else begin
                            r_rdata0 <= r_write ? 32'd0 : dm_rdata;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: a transaction-level model checks every output on every
// falling edge, and directed tests pin key cycles with literal expectations.
module tb_dm_port_arbiter;

    localparam int LAT = 2;
    localparam int LIM = 3;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic [1:0]  req0_size, req1_size;
    logic [31:0] dm_rdata;

    logic        a_req0_ready, a_req0_rvalid, a_req1_ready, a_req1_rvalid;
    logic [31:0] a_req0_rdata, a_req1_rdata, a_dm_addr, a_dm_wdata;
    logic [1:0]  a_dm_size;
    logic        a_dm_read, a_dm_write;

    logic        b_req0_ready, b_req0_rvalid, b_req1_ready, b_req1_rvalid;
    logic [31:0] b_req0_rdata, b_req1_rdata, b_dm_addr, b_dm_wdata;
    logic [1:0]  b_dm_size;
    logic        b_dm_read, b_dm_write;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int rd_run = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    dm_port_arbiter #(.MEM_LAT(LAT), .STARVE_LIMIT(LIM)) u_dut (
        .CLK(CLK), .RESET(RESET),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_size(req0_size), .req0_ready(a_req0_ready),
        .req0_rvalid(a_req0_rvalid), .req0_rdata(a_req0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_size(req1_size), .req1_ready(a_req1_ready),
        .req1_rvalid(a_req1_rvalid), .req1_rdata(a_req1_rdata),
        .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata), .dm_size(a_dm_size),
        .dm_read(a_dm_read), .dm_write(a_dm_write), .dm_rdata(dm_rdata)
    );

    // Pure-priority instance sharing the same stimulus.
    dm_port_arbiter #(.MEM_LAT(LAT), .STARVE_LIMIT(0)) u_dut_pp (
        .CLK(CLK), .RESET(RESET),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_size(req0_size), .req0_ready(b_req0_ready),
        .req0_rvalid(b_req0_rvalid), .req0_rdata(b_req0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_size(req1_size), .req1_ready(b_req1_ready),
        .req1_rvalid(b_req1_rvalid), .req1_rdata(b_req1_rdata),
        .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata), .dm_size(b_dm_size),
        .dm_read(b_dm_read), .dm_write(b_dm_write), .dm_rdata(dm_rdata)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        if (addr == 32'h100) return 32'hDEADBEEF;
        return addr ^ 32'hA5A5_0000;
    endfunction

    // Memory model: read data is only meaningful in the final cycle of a read burst.
    always @(posedge CLK) begin
        #1;
        if (!RESET || !a_dm_read) rd_run = 0;
        else rd_run++;
        dm_rdata = (a_dm_read && rd_run == LAT) ? mem_data(a_dm_addr) : {16'hBAD0, cyc[15:0]};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          m_since  = -1;   // cycles since accept; -1 when no access is in flight
    int          m_starve = 0;
    int          m_owner  = 0;
    logic        m_write;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_size;
    logic [31:0] m_rd [2];
    logic        g0, g1, m_busy, m_resp;
    logic        e_rdy0, e_rdy1, e_rv0, e_rv1, e_rd_s, e_wr_s;
    logic [31:0] e_rd0, e_rd1, e_addr, e_wdata;
    logic [1:0]  e_size;

    always @(negedge CLK) begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!RESET) begin
            m_since = -1; m_starve = 0; m_rd[0] = 32'd0; m_rd[1] = 32'd0;
            m_busy = 1'b0; m_resp = 1'b0;
        end else begin
            if (m_since < 0) begin
                g1 = req1_valid && (!req0_valid || (LIM != 0 && m_starve == LIM));
                g0 = req0_valid && !g1;
            end
            m_busy = (m_since >= 1) && (m_since <= LAT);
            m_resp = (m_since == LAT + 1);
        end
        e_rdy0  = g0;
        e_rdy1  = g1;
        e_rv0   = m_resp && (m_owner == 0);
        e_rv1   = m_resp && (m_owner == 1);
        e_rd0   = m_rd[0];
        e_rd1   = m_rd[1];
        e_rd_s  = m_busy && !m_write;
        e_wr_s  = m_busy && m_write;
        e_addr  = m_busy ? m_addr  : 32'd0;
        e_wdata = m_busy ? m_wdata : 32'd0;
        e_size  = m_busy ? m_size  : 2'd0;

        chk("req0_ready",  a_req0_ready,  e_rdy0);
        chk("req1_ready",  a_req1_ready,  e_rdy1);
        chk("req0_rvalid", a_req0_rvalid, e_rv0);
        chk("req1_rvalid", a_req1_rvalid, e_rv1);
        chk("req0_rdata",  a_req0_rdata,  e_rd0);
        chk("req1_rdata",  a_req1_rdata,  e_rd1);
        chk("dm_read",     a_dm_read,     e_rd_s);
        chk("dm_write",    a_dm_write,    e_wr_s);
        chk("dm_addr",     a_dm_addr,     e_addr);
        chk("dm_wdata",    a_dm_wdata,    e_wdata);
        chk("dm_size",     a_dm_size,     e_size);

        if (RESET) begin
            if (m_since < 0) begin
                if (g0 || g1) begin
                    m_owner = g1 ? 1 : 0;
                    m_write = g1 ? req1_write : req0_write;
                    m_addr  = g1 ? req1_addr  : req0_addr;
                    m_wdata = g1 ? req1_wdata : req0_wdata;
                    m_size  = g1 ? req1_size  : req0_size;
                    m_since = 1;
                    if (g0 && req1_valid) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
                    else m_starve = 0;
                    $display("txn: cycle %0d port%0d %s addr=%08h wdata=%08h size=%0d",
                             cyc, m_owner, m_write ? "store" : "load", m_addr, m_wdata, m_size);
                end
            end else if (m_since == LAT + 1) begin
                m_since = -1;
            end else begin
                if (m_since == LAT) m_rd[m_owner] = m_write ? 32'd0 : dm_rdata;
                m_since++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        repeat (LAT + 3) tick();
    endtask

    // Present a request and hold it until accepted; returns one cycle after acceptance (first BUSY cycle).
    task automatic issue(input int port, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size);
        logic got;
        got = 1'b0;
        if (port == 0) begin
            req0_valid = 1'b1; req0_write = wr; req0_addr = addr; req0_wdata = wdata; req0_size = size;
        end else begin
            req1_valid = 1'b1; req1_write = wr; req1_addr = addr; req1_wdata = wdata; req1_size = size;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if ((port == 0) ? a_req0_ready : a_req1_ready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("grant_seen", got, 1'b1);
        tick();
        if (port == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    int   grants[$];
    int   exp_order [8];
    int   b0, b1, n;

    initial begin
        RESET = 1'b0;
        req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0; req0_size = 0;
        req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0; req1_size = 0;
        dm_rdata = 32'd0;
        repeat (2) tick();

        // T1: random inputs under reset, then release
        repeat (5) begin
            tick();
            req0_valid = 1'($urandom_range(0, 1)); req0_write = 1'($urandom_range(0, 1));
            req0_addr = $urandom; req0_wdata = $urandom; req0_size = 2'($urandom_range(0, 3));
            req1_valid = 1'($urandom_range(0, 1)); req1_write = 1'($urandom_range(0, 1));
            req1_addr = $urandom; req1_wdata = $urandom; req1_size = 2'($urandom_range(0, 3));
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge CLK);
        chk("t1_rst_ready0", a_req0_ready, 1'b0);
        chk("t1_rst_ready1", a_req1_ready, 1'b0);
        tick();
        req0_valid = 0; req1_valid = 0; req0_write = 0; req1_write = 0;
        RESET = 1'b1;
        @(negedge CLK);
        chk("t1_idle_ready0", a_req0_ready, 1'b0);
        tick();
        req0_valid = 1'b1; req0_addr = 32'h0; req0_size = 2'd0;
        @(negedge CLK);
        chk("t1_ready_follows", a_req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        drain();

        // T2: port-0 load
        issue(0, 1'b0, 32'h100, 32'h0, 2'd0);
        @(negedge CLK);
        chk("t2_c1_read", a_dm_read, 1'b1);
        chk("t2_c1_addr", a_dm_addr, 32'h100);
        tick();
        @(negedge CLK);
        chk("t2_c2_read", a_dm_read, 1'b1);
        chk("t2_c2_addr", a_dm_addr, 32'h100);
        tick();
        @(negedge CLK);
        chk("t2_c3_rvalid", a_req0_rvalid, 1'b1);
        chk("t2_c3_rdata", a_req0_rdata, 32'hDEADBEEF);
        tick();
        @(negedge CLK);
        chk("t2_c4_read", a_dm_read, 1'b0);
        chk("t2_c4_rvalid", a_req0_rvalid, 1'b0);
        tick();

        // T3: port-1 byte store
        issue(1, 1'b1, 32'h203, 32'h0000_00AB, 2'd1);
        for (int c = 1; c <= LAT; c++) begin
            @(negedge CLK);
            chk("t3_write", a_dm_write, 1'b1);
            chk("t3_size", a_dm_size, 2'd1);
            chk("t3_wdata", a_dm_wdata, 32'hAB);
            tick();
        end
        @(negedge CLK);
        chk("t3_rvalid1", a_req1_rvalid, 1'b1);
        chk("t3_rdata1", a_req1_rdata, 32'd0);
        chk("t3_rvalid0", a_req0_rvalid, 1'b0);
        tick();

        // Mixed traffic, checked by the model
        issue(0, 1'b1, 32'h10, 32'h0000_1234, 2'd2);
        drain();
        issue(1, 1'b0, 32'h44, 32'h0, 2'd0);
        drain();
        issue(0, 1'b0, 32'h48, 32'h0, 2'd3);
        drain();

        // T4: both valid continuously
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        req0_valid = 1; req0_write = 0; req0_addr = 32'h400; req0_size = 0;
        req1_valid = 1; req1_write = 0; req1_addr = 32'h500; req1_size = 0;
        b0 = 0; b1 = 0;
        for (int i = 0; i < 100 && grants.size() < 8; i++) begin
            @(negedge CLK);
            if (a_req0_ready) grants.push_back(0);
            if (a_req1_ready) grants.push_back(1);
            if (b_req0_ready) b0++;
            if (b_req1_ready) b1++;
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        exp_order = '{0, 0, 0, 1, 0, 0, 0, 1};
        chk("t4_grant_count", grants.size(), 8);
        if (grants.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("t4_grant_order", grants[i], exp_order[i]);
        end
        chk("t4_pp_port1_grants", b1, 0);
        chk("t4_pp_port0_grants", b0, 8);
        drain();

        // T5: port 0 arrives while port 1 is being served
        issue(1, 1'b0, 32'h600, 32'h0, 2'd0);
        req0_valid = 1; req0_write = 0; req0_addr = 32'h700; req0_size = 0;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (a_req0_ready) break;
            tick();
            n++;
        end
        chk("t5_ready0_delay", n, LAT + 2);
        tick();
        req0_valid = 0;
        drain();

        // T6: reset in the 2nd BUSY cycle
        issue(0, 1'b0, 32'h300, 32'h0, 2'd0);
        @(negedge CLK);
        chk("t6_c1_read", a_dm_read, 1'b1);
        tick();
        RESET = 1'b0;
        #1;
        chk("t6_read_drop", a_dm_read, 1'b0);
        tick();
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("t6_no_rvalid", a_req0_rvalid, 1'b0);
            tick();
        end
        issue(0, 1'b0, 32'h304, 32'h0, 2'd0);
        @(negedge CLK);
        tick();
        @(negedge CLK);
        tick();
        @(negedge CLK);
        chk("t6_next_rvalid", a_req0_rvalid, 1'b1);
        chk("t6_next_rdata", a_req0_rdata, mem_data(32'h304));
        tick();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
